// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, size helpers and streamer state encoding
package conv_pkg;
    localparam int Img_Dim_Def = 4;
    localparam int Img_Ch_Def  = 3;
    localparam int Data_W_Def  = 8;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    function automatic int frame_elems(input int dim, input int ch);
        return dim * dim * ch;
    endfunction

    // A one-element frame still needs a one-bit address bus
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_frame_ram.sv
// conv_frame_ram: N x Data_W frame store, synchronous write and registered read
module conv_frame_ram #(
    parameter int N      = 48,
    parameter int AW     = 6,
    parameter int Data_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [Data_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [Data_W-1:0] rdata
);
    logic [Data_W-1:0] mem [N];

    // Frame contents survive reset; only the write strobe updates them
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register doubles as the stream output and holds between reads
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/conv_img_streamer.sv
// conv_img_streamer: streams a stored frame as a channel-interleaved byte stream
module conv_img_streamer
    import conv_pkg::*;
#(
    parameter int Img_Dim = Img_Dim_Def,
    parameter int Img_Ch  = Img_Ch_Def,
    parameter int Data_W  = Data_W_Def,
    localparam int N      = frame_elems(Img_Dim, Img_Ch),
    localparam int AW     = addr_width(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [Data_W-1:0] wr_data,
    input  logic              start,
    input  logic              reverse,
    input  logic              hold,
    output logic [Data_W-1:0] img_stream,
    output logic              img_valid,
    output logic              busy,
    output logic              frame_done
);
    localparam logic [AW-1:0] last_idx = AW'(N - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic          dir;
    logic          beat;
    logic          wr_ok;
    logic          at_end;

    assign beat   = !rst && state == STREAM && !hold;
    assign wr_ok  = !rst && wr_en && state == IDLE && 32'(wr_addr) < N;
    assign at_end = idx == (dir ? '0 : last_idx);
    assign busy   = state != IDLE;

    conv_frame_ram #(.N(N), .AW(AW), .Data_W(Data_W)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (beat),
        .raddr (idx),
        .rdata (img_stream)
    );

    // Frame sequencer: DONE spans two cycles so busy stays high through the frame_done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            dir        <= 1'b0;
            img_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    img_valid  <= 1'b0;
                    frame_done <= 1'b0;
                    if (start) begin
                        dir   <= reverse;
                        idx   <= reverse ? last_idx : '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    img_valid <= !hold;
                    if (!hold) begin
                        if (at_end) state <= DONE;
                        else idx <= dir ? idx - 1'b1 : idx + 1'b1;
                    end
                end
                DONE: begin
                    img_valid  <= 1'b0;
                    frame_done <= !frame_done;
                    if (frame_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_img_streamer.sv
// tb_conv_img_streamer: directed and randomized frame streaming against a frame-level model
module tb_conv_img_streamer;
    localparam int N = 48;

    logic       clk = 1'b0;
    logic       rst, wr_en, start, reverse, hold;
    logic [5:0] wr_addr;
    logic [7:0] wr_data, img_stream;
    logic       img_valid, busy, frame_done;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ref_mem [N];
    logic [7:0] last_out;

    always #5 clk = ~clk;

    conv_img_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .reverse    (reverse),
        .hold       (hold),
        .img_stream (img_stream),
        .img_valid  (img_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a[5:0];
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a < N) ref_mem[a] = d;
    endtask

    // mode: 0 no hold, 1 five holds after beat 23, 2 random holds, 3 toggling hold,
    // 4 hold high at start, 5 start+write mid-frame, 6 write on the start edge
    task automatic run_frame(input bit rev, input int mode);
        logic [7:0] exp [$];
        int k, cyc, hcnt;
        bit h;
        logic [7:0] d0;
        d0 = 8'($urandom);
        if (mode == 6) begin
            ref_mem[0] = d0;
            wr_en = 1'b1;
            wr_addr = 6'd0;
            wr_data = d0;
        end
        for (int i = 0; i < N; i++) exp.push_back(ref_mem[rev ? N - 1 - i : i]);
        hold = (mode == 4);
        reverse = rev;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid", img_valid, 0);
        k = 0;
        cyc = 0;
        hcnt = 0;
        while (k < N && cyc < 500) begin
            case (mode)
                1: h = k >= 24 && hcnt < 5;
                2: h = $urandom_range(0, 2) == 0;
                3: h = cyc[0];
                4: h = cyc < 3;
                default: h = 1'b0;
            endcase
            if (h && mode == 1) hcnt++;
            if (mode == 5 && k == 10) begin
                start = 1'b1;
                reverse = ~rev;
                wr_en = 1'b1;
                wr_addr = 6'd5;
                wr_data = 8'hAA;
            end
            hold = h;
            tick();
            start = 1'b0;
            wr_en = 1'b0;
            cyc++;
            if (!h) begin
                check("beat_valid", img_valid, 1);
                check("beat_data", img_stream, exp[k]);
                last_out = exp[k];
                k++;
            end else begin
                check("hold_valid", img_valid, 0);
                check("hold_data", img_stream, last_out);
            end
            check("mid_done", frame_done, 0);
            check("mid_busy", busy, 1);
        end
        check("beats_timeout", k, N);
        hold = 1'b0;
        tick();
        check("done_pulse", frame_done, 1);
        check("done_valid", img_valid, 0);
        check("done_busy", busy, 1);
        tick();
        check("done_clear", frame_done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        start = 1'b0;
        reverse = 1'b0;
        hold = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        last_out = '0;
        tick();
        tick();
        check("rst_stream", img_stream, 0);
        check("rst_valid", img_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) write(i, 8'(i));
        run_frame(1'b0, 0);
        run_frame(1'b0, 1);
        run_frame(1'b1, 0);
        run_frame(1'b0, 5);
        write(48, 8'hAA);
        run_frame(1'b0, 0);
        run_frame(1'b1, 4);
        run_frame(1'b0, 3);
        reverse = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("pre_rst_data", img_stream, ref_mem[i]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_out = '0;
        check("mid_rst_valid", img_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_data", img_stream, 0);
        run_frame(1'b0, 0);
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 8; w++) write($urandom_range(0, 63), 8'($urandom));
            case (r % 4)
                0: run_frame(1'($urandom), 2);
                1: run_frame(1'($urandom), 6);
                2: run_frame(1'($urandom), 3);
                default: run_frame(1'($urandom), 4);
            endcase
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
